// File: rtl/conv_cnn_engine.sv
// conv_cnn_engine: 3x3 conv + ReLU (two kernels), 2x2 max-pool and interleaved flatten of a
// 64x64 Q4.16 image. All maps live in external memories; one tap or one word moves per cycle.
module conv_cnn_engine #(
  parameter int          DW    = 20,
  parameter int          AW    = 12,
  parameter logic [19:0] BIAS0 = 20'h01310,
  parameter logic [19:0] BIAS1 = 20'hF7295
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);
  localparam int ACCW = 44;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_L0, S_L1, S_DONE} state_t;

  function automatic logic signed [DW-1:0] k0_w(input logic [3:0] t);
    case (t)
      4'd0:    k0_w = 20'sh0A89E;
      4'd1:    k0_w = 20'sh092D5;
      4'd2:    k0_w = 20'sh06D43;
      4'd3:    k0_w = 20'sh01004;
      4'd4:    k0_w = 20'shF8F71;
      4'd5:    k0_w = 20'shF6E54;
      4'd6:    k0_w = 20'shFA6D7;
      4'd7:    k0_w = 20'shFC834;
      default: k0_w = 20'shFAC19;
    endcase
  endfunction

  function automatic logic signed [DW-1:0] k1_w(input logic [3:0] t);
    case (t)
      4'd0:    k1_w = 20'shFDB55;
      4'd1:    k1_w = 20'sh02992;
      4'd2:    k1_w = 20'shFC994;
      4'd3:    k1_w = 20'sh050FD;
      4'd4:    k1_w = 20'sh02F20;
      4'd5:    k1_w = 20'sh0202D;
      4'd6:    k1_w = 20'sh03BD7;
      4'd7:    k1_w = 20'shFD369;
      default: k1_w = 20'sh05E68;
    endcase
  endfunction

  // Half-up rounding of the Q8.32 accumulator back to Q4.16, then ReLU.
  function automatic logic [DW-1:0] round_relu(input logic signed [ACCW-1:0] acc);
    logic [DW-1:0] r;
    r = acc[35:16] + {{(DW-1){1'b0}}, acc[15]};
    round_relu = r[DW-1] ? '0 : r;
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    smax = (a > b) ? a : b;
  endfunction

  state_t state_q, state_d;
  logic busy_q, busy_d, pend_q, pend_d, last_q, last_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [3:0] tap_q, tap_d, step_q, step_d;
  logic [9:0] cell_q, cell_d;
  logic signed [ACCW-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [DW-1:0] hold_q, hold_d;
  logic signed [DW-1:0] max_q, max_d;
  logic cwr_q, cwr_d, crd_q, crd_d;
  logic [2:0] csel_q, csel_d;
  logic [AW-1:0] caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DW-1:0] cdata_wr_q, cdata_wr_d;

  logic [1:0] tr, tc;
  logic [6:0] nr, nc;
  logic inb;
  logic signed [2*DW-1:0] px, w0, w1, p0, p1;
  logic signed [ACCW-1:0] p0_x, p1_x, bias0_x, bias1_x;
  logic [3:0] rt;
  logic signed [DW-1:0] mx_new;

  // Tap geometry: a neighbour row/col of -1 or 64 sets bit 6 and is masked out.
  always_comb begin
    tr      = 2'(tap_q / 4'd3);
    tc      = 2'(tap_q % 4'd3);
    nr      = {1'b0, pix_q[11:6]} + {5'b0, tr} - 7'd1;
    nc      = {1'b0, pix_q[5:0]} + {5'b0, tc} - 7'd1;
    inb     = ~nr[6] & ~nc[6];
    iaddr   = (state_q == S_L0 && inb) ? {nr[5:0], nc[5:0]} : '0;
    px      = {{DW{idata[DW-1]}}, idata};
    w0      = {{DW{k0_w(tap_q)}}, k0_w(tap_q)};
    w1      = {{DW{k1_w(tap_q)}}, k1_w(tap_q)};
    w0      = {{DW{w0[DW-1]}}, w0[DW-1:0]};
    w1      = {{DW{w1[DW-1]}}, w1[DW-1:0]};
    p0      = px * w0;
    p1      = px * w1;
    p0_x    = inb ? {{(ACCW-2*DW){p0[2*DW-1]}}, p0} : '0;
    p1_x    = inb ? {{(ACCW-2*DW){p1[2*DW-1]}}, p1} : '0;
    bias0_x = {{(ACCW-DW-16){BIAS0[DW-1]}}, BIAS0, 16'b0};
    bias1_x = {{(ACCW-DW-16){BIAS1[DW-1]}}, BIAS1, 16'b0};
  end

  always_comb begin
    state_d = state_q;  busy_d = busy_q;  pix_d = pix_q;  tap_d = tap_q;
    pend_d = pend_q;    last_d = last_q;  cell_d = cell_q; step_d = step_q;
    acc0_d = acc0_q;    acc1_d = acc1_q;  hold_d = hold_q; max_d = max_q;
    cwr_d = 1'b0;       crd_d = 1'b0;     csel_d = 3'b000;
    caddr_wr_d = caddr_wr_q; cdata_wr_d = cdata_wr_q; caddr_rd_d = caddr_rd_q;
    rt     = (step_q < 4'd6) ? step_q : step_q - 4'd6;
    mx_new = (step_q == 4'd1 || step_q == 4'd7) ? $signed(cdata_rd) : smax(max_q, cdata_rd);
    if (crd_q) max_d = mx_new;
    case (state_q)
      S_IDLE: if (ready) begin
        busy_d = 1'b1; state_d = S_L0; pix_d = '0; tap_d = '0;
        cell_d = '0;   step_d = '0;    pend_d = 1'b0; last_d = 1'b0;
      end
      S_L0: begin
        // Kernel-1 result of the previous pixel goes out while the next pixel starts.
        if (pend_q) begin
          cwr_d = 1'b1; csel_d = 3'b010; caddr_wr_d = pix_q - ONE; cdata_wr_d = hold_q;
          pend_d = 1'b0;
        end
        if (last_q) begin
          last_d = 1'b0; state_d = S_L1;
        end else begin
          acc0_d = ((tap_q == 4'd0) ? bias0_x : acc0_q) + p0_x;
          acc1_d = ((tap_q == 4'd0) ? bias1_x : acc1_q) + p1_x;
          if (tap_q == 4'd8) begin
            cwr_d = 1'b1; csel_d = 3'b001; caddr_wr_d = pix_q; cdata_wr_d = round_relu(acc0_d);
            hold_d = round_relu(acc1_d); pend_d = 1'b1; tap_d = '0; pix_d = pix_q + ONE;
            last_d = (pix_q == '1);
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      // Per cell: 4 reads k0, L1k0 write, L2 even write, 4 reads k1, L1k1 write, L2 odd write.
      S_L1: begin
        step_d = (step_q == 4'd11) ? 4'd0 : step_q + 4'd1;
        case (step_q)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9: begin
            crd_d = 1'b1; csel_d = (step_q < 4'd6) ? 3'b001 : 3'b010;
            caddr_rd_d = {cell_q[9:5], rt[1], cell_q[4:0], rt[0]};
          end
          4'd4, 4'd10: begin
            cwr_d = 1'b1; csel_d = (step_q == 4'd4) ? 3'b011 : 3'b100;
            caddr_wr_d = {2'b00, cell_q}; cdata_wr_d = mx_new;
          end
          default: begin
            cwr_d = 1'b1; csel_d = 3'b101; cdata_wr_d = max_q;
            caddr_wr_d = {1'b0, cell_q, (step_q == 4'd11)};
            if (step_q == 4'd11) begin
              cell_d = cell_q + 10'd1;
              if (cell_q == '1) state_d = S_DONE;
            end
          end
        endcase
      end
      default: begin
        busy_d = 1'b0; state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; busy_q <= 1'b0; pend_q <= 1'b0; last_q <= 1'b0;
      pix_q <= '0; tap_q <= '0; cell_q <= '0; step_q <= '0;
      cwr_q <= 1'b0; crd_q <= 1'b0; csel_q <= '0;
      caddr_wr_q <= '0; caddr_rd_q <= '0; cdata_wr_q <= '0;
    end else begin
      state_q <= state_d; busy_q <= busy_d; pend_q <= pend_d; last_q <= last_d;
      pix_q <= pix_d; tap_q <= tap_d; cell_q <= cell_d; step_q <= step_d;
      cwr_q <= cwr_d; crd_q <= crd_d; csel_q <= csel_d;
      caddr_wr_q <= caddr_wr_d; caddr_rd_q <= caddr_rd_d; cdata_wr_q <= cdata_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    acc0_q <= acc0_d; acc1_q <= acc1_d; hold_q <= hold_d; max_q <= max_d;
  end

  assign busy     = busy_q;
  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign csel     = csel_q;
  assign caddr_wr = caddr_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign cdata_wr = cdata_wr_q;
endmodule

// File: tb/tb_conv_cnn_engine.sv
// Scoreboard bench for conv_cnn_engine: per-memory queues of expected writes from a longint
// reference model; external memories emulated here and fed back to the engine.
module tb_conv_cnn_engine;
  localparam logic [19:0] BIAS0 = 20'h01310;
  localparam logic [19:0] BIAS1 = 20'hF7295;

  typedef struct packed { logic [11:0] a; logic [19:0] d; } wr_t;

  logic clk = 1'b0, reset = 1'b1, ready = 1'b1;
  logic busy, crd, cwr;
  logic [11:0] iaddr, caddr_rd, caddr_wr;
  logic [19:0] idata = '0, cdata_rd = '0, cdata_wr;
  logic [2:0] csel;

  logic [19:0] img [4096];
  logic [19:0] cm [8][4096];
  logic [19:0] g0 [4096];
  logic [19:0] g1 [4096];
  logic [19:0] kw [2][9] = '{'{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                              20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19},
                             '{20'hFDB55, 20'h02992, 20'hFC994, 20'h050FD, 20'h02F20,
                              20'h0202D, 20'h03BD7, 20'hFD369, 20'h05E68}};
  wr_t sbq [6][$];
  int n_chk = 0, n_pass = 0, falls = 0;

  conv_cnn_engine dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [19:0] conv_px(input int r, input int c, input int k);
    longint acc, rr;
    acc = longint'($signed(k == 0 ? BIAS0 : BIAS1)) * 65536;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < 64 && c + dc >= 0 && c + dc < 64)
          acc += longint'($signed(img[(r + dr) * 64 + c + dc])) *
                 longint'($signed(kw[k][(dr + 1) * 3 + dc + 1]));
    rr = (acc + 32768) >>> 16;
    if (rr < 0) return 20'h0;
    return 20'(rr);
  endfunction

  function automatic logic [19:0] pool(input int cl, input int k);
    logic [19:0] best, v;
    int r, c;
    r = cl / 32; c = cl % 32;
    best = (k == 0) ? g0[(2 * r) * 64 + 2 * c] : g1[(2 * r) * 64 + 2 * c];
    for (int i = 1; i < 4; i++) begin
      v = (k == 0) ? g0[(2 * r + i / 2) * 64 + 2 * c + i % 2] : g1[(2 * r + i / 2) * 64 + 2 * c + i % 2];
      if ($signed(v) > $signed(best)) best = v;
    end
    return best;
  endfunction

  // Ones block (top-left), zero band with a single-LSB pixel, a zero block, random elsewhere.
  task automatic build_image();
    int r, c;
    for (int p = 0; p < 4096; p++) begin
      r = p / 64; c = p % 64;
      if (r < 8 && c < 32) img[p] = 20'h10000;
      else if (r < 16) img[p] = (r == 10 && c == 10) ? 20'h00001 : 20'h0;
      else if (r >= 40 && r < 48 && c >= 32) img[p] = 20'h0;
      else img[p] = 20'($urandom_range(0, 262143) - 131072);
    end
    for (int p = 0; p < 4096; p++) begin
      g0[p] = conv_px(p / 64, p % 64, 0);
      g1[p] = conv_px(p / 64, p % 64, 1);
    end
  endtask

  task automatic push_frame();
    wr_t e;
    logic [19:0] m0, m1;
    for (int i = 0; i < 6; i++) sbq[i].delete();
    for (int p = 0; p < 4096; p++) begin
      e.a = 12'(p); e.d = g0[p]; sbq[0].push_back(e);
      e.d = g1[p]; sbq[1].push_back(e);
    end
    for (int cl = 0; cl < 1024; cl++) begin
      m0 = pool(cl, 0); m1 = pool(cl, 1);
      e.a = 12'(cl); e.d = m0; sbq[2].push_back(e);
      e.d = m1; sbq[3].push_back(e);
      e.a = 12'(2 * cl); e.d = m0; sbq[4].push_back(e);
      e.a = 12'(2 * cl + 1); e.d = m1; sbq[5].push_back(e);
    end
  endtask

  task automatic sb_write(input logic [2:0] sel, input logic [11:0] a, input logic [19:0] d);
    int s;
    wr_t e;
    cm[sel][a] = d;
    case (sel)
      3'd1: s = 0;
      3'd2: s = 1;
      3'd3: s = 2;
      3'd4: s = 3;
      3'd5: s = a[0] ? 5 : 4;
      default: s = -1;
    endcase
    if (s < 0) chk("wr_csel_valid", {29'd0, sel}, 32'd5);
    else if (sbq[s].size() == 0) chk($sformatf("wr_unexpected_sel%0d_addr", sel), {20'd0, a}, 32'hFFFFFFFF);
    else begin
      e = sbq[s].pop_front();
      chk($sformatf("wr_addr_sel%0d", sel), {20'd0, a}, {20'd0, e.a});
      chk($sformatf("wr_data_sel%0d_addr%0d", sel, a), {12'd0, d}, {12'd0, e.d});
    end
  endtask

  // Memory side: capture writes mid-cycle, then present read data for the coming edge.
  always @(negedge clk) begin
    if (!reset && cwr) sb_write(csel, caddr_wr, cdata_wr);
    idata = img[iaddr];
    cdata_rd = crd ? cm[csel][caddr_rd] : 20'h0;
  end

  always @(negedge busy) if (!reset) falls++;

  task automatic wait_busy(input logic val, input int maxc, input string name);
    int n;
    n = 0;
    while (busy !== val && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk(name, {31'd0, busy}, {31'd0, val});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cwr_crd"}, {30'd0, cwr, crd}, 32'd0);
    chk({tag, "_csel"}, {29'd0, csel}, 32'd0);
    chk({tag, "_addrs"}, {iaddr, caddr_rd, 8'd0} | {20'd0, caddr_wr}, 32'd0);
    chk({tag, "_cdata_wr"}, {12'd0, cdata_wr}, 32'd0);
  endtask

  initial begin
    build_image();
    push_frame();
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;
    wait_busy(1'b1, 2, "busy_rise");
    repeat (300) @(posedge clk);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("busy_async_drop", {31'd0, busy}, 32'd0);
    chk("cwr_async_drop", {31'd0, cwr}, 32'd0);
    @(negedge clk);
    chk_reset_outputs("midreset");
    push_frame();
    @(negedge clk); reset = 1'b0;
    wait_busy(1'b1, 2, "busy_rise_restart");
    falls = 0;
    @(negedge clk); ready = 1'b0;
    wait_busy(1'b0, 60000, "busy_fall");
    chk("sb_drained", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() +
                          sbq[3].size() + sbq[4].size() + sbq[5].size()), 32'd0);
    repeat (20) @(posedge clk);
    #1 chk("busy_stays_low", {31'd0, busy}, 32'd0);
    chk("busy_fall_count", 32'(falls), 32'd1);
    chk("ones_L0k0_interior", {12'd0, cm[1][3 * 64 + 5]}, 32'h0);
    chk("ones_L0k1_interior", {12'd0, cm[2][3 * 64 + 5]}, 32'h04F02);
    chk("ones_L0k1_0_5", {12'd0, cm[2][5]}, 32'h08087);
    chk("ones_L0k1_0_0", {12'd0, cm[2][0]}, 32'h0);
    chk("ones_L1k1_33", {12'd0, cm[4][33]}, 32'h04F02);
    chk("ones_L2_67", {12'd0, cm[5][67]}, 32'h04F02);
    chk("round_L0k0_650", {12'd0, cm[1][650]}, 32'h01310);
    chk("round_L0k0_651", {12'd0, cm[1][651]}, 32'h01310);
    chk("zero_L0k0", {12'd0, cm[1][44 * 64 + 50]}, 32'h01310);
    chk("zero_L0k1", {12'd0, cm[2][44 * 64 + 50]}, 32'h0);
    chk("zero_L1k0", {12'd0, cm[3][22 * 32 + 28]}, 32'h01310);
    chk("zero_L1k1", {12'd0, cm[4][22 * 32 + 28]}, 32'h0);
    chk("zero_L2_even", {12'd0, cm[5][2 * (22 * 32 + 28)]}, 32'h01310);
    chk("zero_L2_odd", {12'd0, cm[5][2 * (22 * 32 + 28) + 1]}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
